// File: rtl/flow_ctrl_fsm_if.sv
// Flow-control bundle: threshold load, FIFO status in, state/status out.
// master drives init/err_clr/thresholds/FIFO flags; slave is the FSM.
interface flow_ctrl_fsm_if #(
    parameter int NFIFO = 5,
    parameter int TW    = 8
);
    logic             init;
    logic             err_clr;
    logic [TW-1:0]    umf_in;
    logic [TW-1:0]    uvc_in;
    logic [TW-1:0]    ud_in;
    logic [NFIFO-1:0] fifo_empty;
    logic [NFIFO-1:0] fifo_error;
    logic [TW-1:0]    umf_out;
    logic [TW-1:0]    uvc_out;
    logic [TW-1:0]    ud_out;
    logic [2:0]       state;
    logic             idle_out;
    logic             active_out;
    logic             error_out;
    logic [NFIFO-1:0] error_vec;

    modport master (
        output init, err_clr, umf_in, uvc_in, ud_in,
        output fifo_empty, fifo_error,
        input  umf_out, uvc_out, ud_out,
        input  state, idle_out, active_out, error_out,
        input  error_vec
    );

    modport slave (
        input  init, err_clr, umf_in, uvc_in, ud_in,
        input  fifo_empty, fifo_error,
        output umf_out, uvc_out, ud_out,
        output state, idle_out, active_out, error_out,
        output error_vec
    );
endinterface

// File: rtl/flow_ctrl_fsm.sv
// Flow-control FSM: loads FIFO thresholds, tracks idle/active, latches errors.
// Ports: clk, reset (async, active-high), bus (flow_ctrl_fsm_if.slave).
module flow_ctrl_fsm #(
    parameter int NFIFO    = 5,
    parameter int TW       = 8,
    parameter int IDLE_CNT = 4
) (
    input  logic           clk,
    input  logic           reset,
    flow_ctrl_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [7:0] LP_IDLE_CNT = 8'(IDLE_CNT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [7:0]       w_cnt_inc;
    logic [NFIFO-1:0] r_err_vec;
    logic [NFIFO-1:0] w_err_vec_nxt;
    logic [TW-1:0]    r_umf;
    logic [TW-1:0]    r_uvc;
    logic [TW-1:0]    r_ud;
    logic [TW-1:0]    w_umf_nxt;
    logic [TW-1:0]    w_uvc_nxt;
    logic [TW-1:0]    w_ud_nxt;
    logic             w_any_err;
    logic             w_all_empty;

    assign w_any_err   = |bus.fifo_error;
    assign w_all_empty = &bus.fifo_empty;

    // Saturating increment keeps the run length from wrapping.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RESET;
            r_cnt     <= 8'd0;
            r_err_vec <= '0;
            r_umf     <= '0;
            r_uvc     <= '0;
            r_ud      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err_vec <= w_err_vec_nxt;
            r_umf     <= w_umf_nxt;
            r_uvc     <= w_uvc_nxt;
            r_ud      <= w_ud_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = 8'd0;
        w_err_vec_nxt = r_err_vec | bus.fifo_error;
        w_umf_nxt     = r_umf;
        w_uvc_nxt     = r_uvc;
        w_ud_nxt      = r_ud;

        unique case (r_state)
            S_RESET: begin
                w_state_nxt   = S_INIT;
                w_err_vec_nxt = r_err_vec;
            end
            S_INIT: begin
                w_umf_nxt = bus.umf_in;
                w_uvc_nxt = bus.uvc_in;
                w_ud_nxt  = bus.ud_in;
                if (w_any_err)
                    w_state_nxt = S_ERROR;
                else if (bus.init)
                    w_state_nxt = S_INIT;
                else
                    w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                // Counter stays 0 here so ACTIVE is always entered fresh.
                if (w_any_err)
                    w_state_nxt = S_ERROR;
                else if (bus.init)
                    w_state_nxt = S_INIT;
                else if (!w_all_empty)
                    w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_any_err) begin
                    w_state_nxt = S_ERROR;
                end else if (bus.init) begin
                    w_state_nxt = S_INIT;
                end else if (w_all_empty) begin
                    if (w_cnt_inc >= LP_IDLE_CNT)
                        w_state_nxt = S_IDLE;
                    else
                        w_cnt_nxt = w_cnt_inc;
                end
            end
            S_ERROR: begin
                // A clear coinciding with a new error restarts capture
                // from the new error bits alone.
                if (bus.err_clr) begin
                    w_err_vec_nxt = bus.fifo_error;
                    if (!w_any_err)
                        w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt   = S_RESET;
                w_err_vec_nxt = '0;
            end
        endcase
    end

    assign bus.state      = r_state;
    assign bus.idle_out   = (r_state == S_IDLE);
    assign bus.active_out = (r_state == S_ACTIVE);
    assign bus.error_out  = (r_state == S_ERROR);
    assign bus.error_vec  = r_err_vec;
    assign bus.umf_out    = r_umf;
    assign bus.uvc_out    = r_uvc;
    assign bus.ud_out     = r_ud;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Bench for flow_ctrl_fsm: two instances (5 FIFO/IDLE_CNT 4, 8 FIFO/IDLE_CNT 1)
// driven in lockstep; directed scenarios then randomized traffic vs a model.
module tb_flow_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_init;
    logic       d_clr;
    logic [7:0] d_umf;
    logic [7:0] d_uvc;
    logic [7:0] d_ud;
    logic [7:0] d_emp;
    logic [7:0] d_err;

    always #5 clk = ~clk;

    flow_ctrl_fsm_if #(.NFIFO(5), .TW(8)) ia ();
    flow_ctrl_fsm_if #(.NFIFO(8), .TW(8)) ib ();

    assign ia.init       = d_init;
    assign ia.err_clr    = d_clr;
    assign ia.umf_in     = d_umf;
    assign ia.uvc_in     = d_uvc;
    assign ia.ud_in      = d_ud;
    assign ia.fifo_empty = d_emp[4:0];
    assign ia.fifo_error = d_err[4:0];
    assign ib.init       = d_init;
    assign ib.err_clr    = d_clr;
    assign ib.umf_in     = d_umf;
    assign ib.uvc_in     = d_uvc;
    assign ib.ud_in      = d_ud;
    assign ib.fifo_empty = d_emp;
    assign ib.fifo_error = d_err;

    flow_ctrl_fsm #(.NFIFO(5), .TW(8), .IDLE_CNT(4)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ia)
    );

    flow_ctrl_fsm #(.NFIFO(8), .TW(8), .IDLE_CNT(1)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ib)
    );

    // Model: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
    int         m_st  [2];
    int         m_run [2];
    logic [7:0] m_umf [2];
    logic [7:0] m_uvc [2];
    logic [7:0] m_ud  [2];
    logic [7:0] m_ev  [2];

    int n_tot  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = 0;
            m_run[k] = 0;
            m_umf[k] = 8'h00;
            m_uvc[k] = 8'h00;
            m_ud[k]  = 8'h00;
            m_ev[k]  = 8'h00;
        end
    endtask

    task automatic mstep(input int k);
        logic [7:0] msk;
        logic [7:0] e;
        bit         full;
        int         s;
        int         lim;
        msk  = (k == 0) ? 8'h1F : 8'hFF;
        lim  = (k == 0) ? 4 : 1;
        e    = d_err & msk;
        full = ((d_emp & msk) == msk);
        s    = m_st[k];
        if (s == 0) begin
            m_st[k] = 1;
            return;
        end
        if (s == 4 && d_clr) m_ev[k] = e;
        else m_ev[k] = m_ev[k] | e;
        if (s == 1) begin
            m_umf[k] = d_umf;
            m_uvc[k] = d_uvc;
            m_ud[k]  = d_ud;
        end
        if (e != 0) m_st[k] = 4;
        else if (s == 4) m_st[k] = d_clr ? 2 : 4;
        else if (d_init) m_st[k] = 1;
        else if (s == 1) m_st[k] = 2;
        else if (s == 2) m_st[k] = full ? 2 : 3;
        else begin
            m_run[k] = full ? m_run[k] + 1 : 0;
            if (m_run[k] >= lim) m_st[k] = 2;
        end
        if (m_st[k] != 3) m_run[k] = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.state",  {29'd0, ia.state}, m_st[0]);
            chk("a.idle",   {31'd0, ia.idle_out}, {31'd0, m_st[0] == 2});
            chk("a.active", {31'd0, ia.active_out}, {31'd0, m_st[0] == 3});
            chk("a.error",  {31'd0, ia.error_out}, {31'd0, m_st[0] == 4});
            chk("a.umf",    {24'd0, ia.umf_out}, {24'd0, m_umf[0]});
            chk("a.uvc",    {24'd0, ia.uvc_out}, {24'd0, m_uvc[0]});
            chk("a.ud",     {24'd0, ia.ud_out}, {24'd0, m_ud[0]});
            chk("a.evec",   {27'd0, ia.error_vec}, {24'd0, m_ev[0] & 8'h1F});
            chk("b.state",  {29'd0, ib.state}, m_st[1]);
            chk("b.idle",   {31'd0, ib.idle_out}, {31'd0, m_st[1] == 2});
            chk("b.active", {31'd0, ib.active_out}, {31'd0, m_st[1] == 3});
            chk("b.error",  {31'd0, ib.error_out}, {31'd0, m_st[1] == 4});
            chk("b.umf",    {24'd0, ib.umf_out}, {24'd0, m_umf[1]});
            chk("b.uvc",    {24'd0, ib.uvc_out}, {24'd0, m_uvc[1]});
            chk("b.ud",     {24'd0, ib.ud_out}, {24'd0, m_ud[1]});
            chk("b.evec",   {24'd0, ib.error_vec}, {24'd0, m_ev[1]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (!rst) begin
            mstep(0);
            mstep(1);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic ini, input logic clr,
                       input logic [7:0] emp, input logic [7:0] err);
        d_init = ini;
        d_clr  = clr;
        d_emp  = emp;
        d_err  = err;
    endtask

    task automatic async_rst();
        #2 rst = 1'b1;
        mreset();
        #1;
        chk("arst.state", {29'd0, ia.state}, 32'd0);
        chk("arst.active", {31'd0, ia.active_out}, 32'd0);
        chk("arst.umf", {24'd0, ia.umf_out}, 32'd0);
        chk("arst.evec", {27'd0, ia.error_vec}, 32'd0);
        chk("arst.b.state", {29'd0, ib.state}, 32'd0);
        @(negedge clk);
        #1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        d_umf = 8'h2A;
        d_uvc = 8'h17;
        d_ud  = 8'h1B;
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        mreset();
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        cyc();
        chk("rst.state", {29'd0, ia.state}, 32'd0);
        chk("rst.umf", {24'd0, ia.umf_out}, 32'd0);
        rst = 1'b0;

        // Threshold load: RESET -> INIT, init for one cycle, then IDLE
        drv(1'b1, 1'b0, 8'hFF, 8'h00);
        cyc();
        chk("init.enter", {29'd0, ia.state}, 32'd1);
        cyc();
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        cyc();
        chk("init.idle", {29'd0, ia.state}, 32'd2);
        chk("init.umf", {24'd0, ia.umf_out}, 32'h2A);
        chk("init.uvc", {24'd0, ia.uvc_out}, 32'h17);
        chk("init.ud", {24'd0, ia.ud_out}, 32'h1B);
        chk("init.idle_out", {31'd0, ia.idle_out}, 32'd1);

        // Idle countdown, clean and with an interrupting not-empty cycle
        drv(1'b0, 1'b0, 8'h03, 8'h00);
        cyc();
        chk("act.enter", {29'd0, ia.state}, 32'd3);
        chk("act.b.enter", {29'd0, ib.state}, 32'd3);
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        cyc();
        chk("act.b.cnt1", {29'd0, ib.state}, 32'd2);
        cyc();
        cyc();
        chk("act.cnt3", {29'd0, ia.state}, 32'd3);
        cyc();
        chk("act.cnt4", {29'd0, ia.state}, 32'd2);
        drv(1'b0, 1'b0, 8'h03, 8'h00);
        cyc();
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        cyc();
        cyc();
        drv(1'b0, 1'b0, 8'h03, 8'h00);
        cyc();
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        cyc();
        cyc();
        cyc();
        chk("act.fresh3", {29'd0, ia.state}, 32'd3);
        cyc();
        chk("act.fresh4", {29'd0, ia.state}, 32'd2);

        // Error capture and clear
        drv(1'b0, 1'b0, 8'h03, 8'h00);
        cyc();
        drv(1'b0, 1'b0, 8'h03, 8'h02);
        cyc();
        chk("err.enter", {29'd0, ia.state}, 32'd4);
        chk("err.vec1", {27'd0, ia.error_vec}, 32'h02);
        chk("err.b.vec1", {24'd0, ib.error_vec}, 32'h02);
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        cyc();
        drv(1'b0, 1'b0, 8'hFF, 8'h04);
        cyc();
        chk("err.vec2", {27'd0, ia.error_vec}, 32'h06);
        drv(1'b0, 1'b1, 8'hFF, 8'h00);
        cyc();
        chk("err.clr", {29'd0, ia.state}, 32'd2);
        chk("err.clrvec", {27'd0, ia.error_vec}, 32'h00);

        // Clear colliding with a new error
        drv(1'b0, 1'b0, 8'hFF, 8'h04);
        cyc();
        drv(1'b0, 1'b1, 8'hFF, 8'h01);
        cyc();
        chk("coll.state", {29'd0, ia.state}, 32'd4);
        chk("coll.vec", {27'd0, ia.error_vec}, 32'h01);
        drv(1'b0, 1'b1, 8'hFF, 8'h00);
        cyc();

        // Reload while idle, init held three cycles
        d_umf = 8'h26;
        d_uvc = 8'h19;
        d_ud  = 8'h1C;
        drv(1'b1, 1'b0, 8'hFF, 8'h00);
        cyc();
        chk("rl.enter", {29'd0, ia.state}, 32'd1);
        chk("rl.old", {24'd0, ia.umf_out}, 32'h2A);
        cyc();
        cyc();
        chk("rl.hold", {29'd0, ia.state}, 32'd1);
        chk("rl.umf", {24'd0, ia.umf_out}, 32'h26);
        drv(1'b0, 1'b0, 8'hFF, 8'h00);
        cyc();
        chk("rl.idle", {29'd0, ia.state}, 32'd2);
        chk("rl.ud", {24'd0, ia.ud_out}, 32'h1C);

        // Error beats init while in INIT
        drv(1'b1, 1'b0, 8'hFF, 8'h00);
        cyc();
        drv(1'b1, 1'b0, 8'hFF, 8'h08);
        cyc();
        chk("initerr.state", {29'd0, ia.state}, 32'd4);
        drv(1'b0, 1'b1, 8'hFF, 8'h00);
        cyc();

        // Asynchronous reset mid-cycle while ACTIVE
        drv(1'b0, 1'b0, 8'h03, 8'h00);
        cyc();
        async_rst();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d_init = ($urandom_range(0, 7) == 0);
            d_clr  = ($urandom_range(0, 3) == 0);
            d_emp  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            d_err  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
            d_umf  = 8'($urandom);
            d_uvc  = 8'($urandom);
            d_ud   = 8'($urandom);
            if ($urandom_range(0, 299) == 0) async_rst();
            cyc();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/flow_ctrl_fsm.md
FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter NFIFO, default 5, meaning the number of monitored FIFOs.
REQ-002 The block SHALL have parameter TW, default 8, meaning the width of each threshold.
REQ-003 The block SHALL have parameter IDLE_CNT, default 4, meaning the number of consecutive all-empty cycles required to leave ACTIVE; legal values are 1..255.
REQ-004 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 init  input  1  request to (re)load thresholds.
REQ-007 err_clr  input  1  single-cycle pulse that clears a latched error.
REQ-008 umf_in, uvc_in, ud_in  input  TW each  candidate thresholds for the main FIFO, the VC FIFOs and the D FIFOs.
REQ-009 fifo_empty  input  NFIFO  per-FIFO empty flags.
REQ-010 fifo_error  input  NFIFO  per-FIFO error flags.
REQ-011 umf_out, uvc_out, ud_out  output  TW each  active thresholds.
REQ-012 state  output  3  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-013 idle_out, active_out, error_out  output  1 each  one-hot decode of IDLE, ACTIVE and ERROR.
REQ-014 error_vec  output  NFIFO  sticky per-FIFO error capture.

Function
REQ-015 state and all status outputs SHALL be decoded from the state register only (Moore), with no combinational path from any input.
REQ-016 RESET SHALL go to INIT on the first rising clk edge after reset deasserts.
REQ-017 In INIT, umf_out/uvc_out/ud_out SHALL load umf_in/uvc_in/ud_in on every cycle; the state SHALL stay in INIT while init=1 and go to IDLE when init=0.
REQ-018 Thresholds SHALL hold their values in every state other than INIT.
REQ-019 In IDLE, transitions SHALL be taken in priority order: any fifo_error bit set -> ERROR; else init=1 -> INIT; else fifo_empty not all ones -> ACTIVE; else stay in IDLE.
REQ-020 In ACTIVE, transitions SHALL be taken in priority order: any fifo_error bit set -> ERROR; else init=1 -> INIT; else IDLE_CNT consecutive cycles with fifo_empty all ones -> IDLE.
REQ-021 A cycle counter SHALL count consecutive all-empty cycles in ACTIVE, clear to 0 on any not-empty cycle and on entry to ACTIVE, and saturate without wrapping.
REQ-022 With IDLE_CNT=1, a single all-empty cycle in ACTIVE SHALL move the state to IDLE.
REQ-023 In INIT, any fifo_error bit set SHALL move the state to ERROR and take priority over init.
REQ-024 ERROR SHALL be held until err_clr=1 or reset; err_clr=1 SHALL move ERROR -> IDLE and clear error_vec in the same edge.
REQ-025 err_clr=1 together with a fifo_error bit set SHALL leave the state in ERROR, with error_vec reloaded from fifo_error only.
REQ-026 error_vec SHALL be updated as error_vec | fifo_error on every edge outside RESET, except as stated in REQ-024 and REQ-025.
REQ-027 err_clr SHALL be ignored outside ERROR.

Reset
REQ-028 Asserting reset at any time, including mid-transition, SHALL immediately force state=RESET, all thresholds to 0, error_vec to 0, the counter to 0, and idle_out/active_out/error_out to 0.
REQ-029 Reset values SHALL hold while reset=1, regardless of clk or any other input.

Verification
REQ-030 The bench SHALL cover: reset, then init=1 for 1 cycle with umf_in=0x2A, uvc_in=0x17, ud_in=0x1B -> INIT then IDLE; thresholds 0x2A/0x17/0x1B; idle_out=1.
REQ-031 The bench SHALL cover: from IDLE, fifo_empty=5'b00011 -> ACTIVE next edge; then all ones for 4 cycles -> IDLE after the 4th edge; with a not-empty cycle inserted at cycle 3 -> still ACTIVE until 4 fresh all-empty cycles.
REQ-032 The bench SHALL cover: in ACTIVE, fifo_error=5'b00010 for 1 cycle -> ERROR with error_vec=00010; fifo_error=00100 later -> error_vec=00110; err_clr pulse -> IDLE with error_vec=0.
REQ-033 The bench SHALL cover: err_clr together with fifo_error=00001 -> state stays ERROR, error_vec=00001.
REQ-034 The bench SHALL cover: in IDLE, init=1 with umf_in=0x26, uvc_in=0x19, ud_in=0x1C -> INIT, thresholds updated; init held 3 cycles -> INIT held; release -> IDLE.
REQ-035 The bench SHALL cover: reset asserted asynchronously between edges while in ACTIVE -> outputs zero before the next clk edge; NFIFO=8, IDLE_CNT=1 rerun of the scenarios in REQ-031 and REQ-032 passes.
